// File: rtl/pci_tgt_seq_pkg.sv
// Shared definitions for the PCI target sequencer.
//   - tgt_st_e  : sequencer state encoding
//   - pci_cmd_e : C/BE# command codes the capture stage decodes from
//   - *_DEF     : default latency limits and counter width
//   - f_hit     : address-phase claim qualifier
package pci_tgt_seq_pkg;

  localparam int INIT_LAT_DEF = 16;
  localparam int SUBS_LAT_DEF = 8;
  localparam int CNT_W_DEF    = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUSY = 3'd1,
    ST_WAIT = 3'd2,
    ST_DATA = 3'd3,
    ST_STOP = 3'd4,
    ST_TURN = 3'd5
  } tgt_st_e;

  typedef enum logic [3:0] {
    CMD_IO_RD  = 4'h2,
    CMD_IO_WR  = 4'h3,
    CMD_MEM_RD = 4'h6,
    CMD_MEM_WR = 4'h7,
    CMD_CFG_RD = 4'hA,
    CMD_CFG_WR = 4'hB
  } pci_cmd_e;

  function automatic logic f_hit(logic first_cyc, logic cfg, logic io, logic mem);
    return first_cyc & (cfg | io | mem);
  endfunction

endpackage

// File: rtl/pci_tgt_seq_if.sv
// Bus/handshake bundle between the capture stage, the PCI pins and the
// local register side.
//   slave  : the target sequencer (consumes qualifiers, drives target pins)
//   master : whatever drives the qualifiers / bus and observes the target
interface pci_tgt_seq_if;
  logic framenid;
  logic irdynid;
  logic first_cyc;
  logic acc_cfg;
  logic acc_io;
  logic acc_mem;
  logic acc_rd;
  logic acc_wr;
  logic loc_ack;
  logic devseln;
  logic trdyn;
  logic stopn;
  logic tgt_oe;
  logic ad_oe;
  logic loc_req;
  logic inc_adr;
  logic acc_end;

  modport slave (
    input  framenid, irdynid, first_cyc, acc_cfg, acc_io, acc_mem,
           acc_rd, acc_wr, loc_ack,
    output devseln, trdyn, stopn, tgt_oe, ad_oe, loc_req, inc_adr, acc_end
  );

  modport master (
    output framenid, irdynid, first_cyc, acc_cfg, acc_io, acc_mem,
           acc_rd, acc_wr, loc_ack,
    input  devseln, trdyn, stopn, tgt_oe, ad_oe, loc_req, inc_adr, acc_end
  );
endinterface

// File: rtl/pci_tgt_seq_lat_cnt.sv
// pci_lat_cnt: loadable down-counter used to time target latency.
//   clk, rst : clock, synchronous active-low reset
//   i_load   : load i_val (has priority over i_dec)
//   i_dec    : decrement, saturating at zero
//   o_cnt    : current count
//   o_zero   : count is zero
module pci_lat_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                       r_cnt <= '0;
    else if (i_load)                r_cnt <= i_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pci_tgt_seq.sv
// PCI target bus sequencer. Claims cfg/io/mem hits with medium DEVSEL#,
// paces the local side via loc_req/loc_ack, completes data phases with
// TRDY#, and retries/disconnects with STOP# when the local side misses the
// initial or subsequent latency budget.
//   clk, rst : PCI clock, synchronous active-low reset
//   bus      : pci_tgt_seq_if.slave (qualifiers in, target pins and
//              local handshake out); all outputs are registered
module pci_tgt_seq
  import pci_tgt_seq_pkg::*;
#(
  parameter int INIT_LAT = INIT_LAT_DEF,
  parameter int SUBS_LAT = SUBS_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pci_tgt_seq_if.slave  bus
);

  tgt_st_e r_state;
  logic    r_devseln, r_trdyn, r_stopn, r_tgt_oe, r_ad_oe;
  logic    r_loc_req, r_inc_adr, r_acc_end, r_single;

  logic             w_hit, w_done, w_load, w_dec, w_zero, w_expire;
  logic [CNT_W-1:0] w_cnt, w_load_val;

  assign w_hit  = f_hit(bus.first_cyc, bus.acc_cfg, bus.acc_io, bus.acc_mem);
  // Data phase completes when both ready strobes are low at the edge.
  assign w_done = ~r_trdyn & ~bus.irdynid;

  // Load on claim (initial budget) and when a burst moves to its next phase.
  assign w_load     = ((r_state == ST_IDLE) & w_hit) |
                      ((r_state == ST_DATA) & w_done & ~bus.framenid & ~r_single);
  assign w_load_val = (r_state == ST_IDLE) ? CNT_W'(INIT_LAT) : CNT_W'(SUBS_LAT);
  assign w_dec      = (r_state == ST_WAIT);
  // The budget is spent on the edge that takes the count to zero, so STOP#
  // appears exactly INIT_LAT/SUBS_LAT clocks after the phase began.
  assign w_expire   = w_zero | (w_cnt == CNT_W'(1));

  pci_lat_cnt #(.CNT_W(CNT_W)) u_lat (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .i_dec  (w_dec),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_devseln <= 1'b1;
      r_trdyn   <= 1'b1;
      r_stopn   <= 1'b1;
      r_tgt_oe  <= 1'b0;
      r_ad_oe   <= 1'b0;
      r_loc_req <= 1'b0;
      r_inc_adr <= 1'b0;
      r_acc_end <= 1'b0;
      r_single  <= 1'b0;
    end else begin
      r_inc_adr <= 1'b0;
      r_acc_end <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state   <= ST_WAIT;
            r_devseln <= 1'b0;
            r_tgt_oe  <= 1'b1;
            r_loc_req <= 1'b1;
            r_ad_oe   <= bus.acc_rd & ~bus.acc_wr;
            r_single  <= bus.acc_cfg | bus.acc_io;
          end else if (bus.first_cyc) begin
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.framenid & bus.irdynid) r_state <= ST_IDLE;
        end
        ST_WAIT: begin
          // Master gave up with no data phase pending: close without inc_adr.
          if (bus.framenid & bus.irdynid) begin
            r_state   <= ST_TURN;
            r_loc_req <= 1'b0;
            r_devseln <= 1'b1;
            r_ad_oe   <= 1'b0;
          end else if (bus.loc_ack) begin
            r_state   <= ST_DATA;
            r_trdyn   <= 1'b0;
            r_loc_req <= 1'b0;
          end else if (w_expire) begin
            r_state   <= ST_STOP;
            r_stopn   <= 1'b0;
            r_loc_req <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_done) begin
            r_inc_adr <= 1'b1;
            r_trdyn   <= 1'b1;
            if (bus.framenid) begin
              r_state   <= ST_TURN;
              r_devseln <= 1'b1;
              r_ad_oe   <= 1'b0;
            end else if (r_single) begin
              r_state <= ST_STOP;
              r_stopn <= 1'b0;
            end else begin
              r_state   <= ST_WAIT;
              r_loc_req <= 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (bus.framenid) begin
            r_state   <= ST_TURN;
            r_stopn   <= 1'b1;
            r_devseln <= 1'b1;
            r_ad_oe   <= 1'b0;
          end
        end
        ST_TURN: begin
          // acc_end lands in the first IDLE cycle so it never overlaps the
          // inc_adr pulse of a final data phase.
          r_state   <= ST_IDLE;
          r_tgt_oe  <= 1'b0;
          r_acc_end <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.devseln = r_devseln;
  assign bus.trdyn   = r_trdyn;
  assign bus.stopn   = r_stopn;
  assign bus.tgt_oe  = r_tgt_oe;
  assign bus.ad_oe   = r_ad_oe;
  assign bus.loc_req = r_loc_req;
  assign bus.inc_adr = r_inc_adr;
  assign bus.acc_end = r_acc_end;

endmodule

// File: tb/tb_pci_tgt_seq.sv
// Bench for pci_tgt_seq. Transactions are planned with random local-side
// and master delays; the expected cycle of every output event is computed
// from the bus timing rules and queued, and a negedge monitor pops and
// compares whenever the target produces an event.
module tb_pci_tgt_seq;

  localparam int INIT_LAT = 16;
  localparam int SUBS_LAT = 8;

  // event kinds, ordered as the monitor scans them within a cycle
  localparam int EV_DEV = 0, EV_TRDY = 1, EV_STOP = 2, EV_INC = 3, EV_END = 4,
                 EV_REQR = 5, EV_REQF = 6, EV_OER = 7, EV_OEF = 8,
                 EV_ADR = 9, EV_ADF = 10;

  typedef struct { int kind; int cyc; } ev_t;

  logic clk, rst;
  int   cyc = 0;
  int   tests = 0, fails = 0;
  bit   mon_en = 0;
  ev_t  exp_q[$];

  pci_tgt_seq_if bus();

  pci_tgt_seq #(.INIT_LAT(INIT_LAT), .SUBS_LAT(SUBS_LAT), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int k, input int t);
    exp_q.push_back('{kind: k, cyc: t});
  endfunction

  // TURN visible at t: ad_oe drops there, acc_end and tgt_oe release next cycle.
  function automatic void push_end(input int t, input bit rd);
    if (rd) push(EV_ADF, t);
    push(EV_END, t + 1);
    push(EV_OEF, t + 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  // monitor
  initial begin
    logic [10:0] ev;
    logic pv_dev, pv_trdy, pv_stop, pv_req, pv_oe, pv_ad;
    ev_t  e;
    pv_dev = 1; pv_trdy = 1; pv_stop = 1; pv_req = 0; pv_oe = 0; pv_ad = 0;
    forever begin
      @(negedge clk);
      ev[EV_DEV]  = pv_dev  & ~bus.devseln;
      ev[EV_TRDY] = pv_trdy & ~bus.trdyn;
      ev[EV_STOP] = pv_stop & ~bus.stopn;
      ev[EV_INC]  = bus.inc_adr;
      ev[EV_END]  = bus.acc_end;
      ev[EV_REQR] = ~pv_req & bus.loc_req;
      ev[EV_REQF] = pv_req  & ~bus.loc_req;
      ev[EV_OER]  = ~pv_oe  & bus.tgt_oe;
      ev[EV_OEF]  = pv_oe   & ~bus.tgt_oe;
      ev[EV_ADR]  = ~pv_ad  & bus.ad_oe;
      ev[EV_ADF]  = pv_ad   & ~bus.ad_oe;
      pv_dev = bus.devseln; pv_trdy = bus.trdyn; pv_stop = bus.stopn;
      pv_req = bus.loc_req; pv_oe = bus.tgt_oe;  pv_ad = bus.ad_oe;
      if (mon_en) begin
        for (int k = 0; k < 11; k++) begin
          if (ev[k]) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL event: got kind=%0d cyc=%0d, expected none", k, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.kind != k || e.cyc != cyc) begin
                fails++;
                $display("FAIL event: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d",
                         k, cyc, e.kind, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  // sp: 0 cfg, 1 io, 2 mem. ev_kind at phase ev_ph: 1 local timeout, 2 master abort.
  // single_hold: cfg/io keeps FRAME# low after its phase (target disconnects).
  task automatic run_txn(input int sp, input bit rd, input int nph_in, input int ev_ph,
                         input int ev_kind, input bit single_hold, input int dfix,
                         input int wfix);
    int H, ws, lim, A, C, X, F, d, w, nph;
    bit single;
    single = (sp != 2);
    nph    = single ? 1 : nph_in;
    bus.framenid = 0; bus.irdynid = 1; bus.first_cyc = 1;
    bus.acc_cfg = (sp == 0); bus.acc_io = (sp == 1); bus.acc_mem = (sp == 2);
    bus.acc_rd = rd; bus.acc_wr = !rd;
    H = cyc;
    push(EV_DEV, H + 1); push(EV_REQR, H + 1); push(EV_OER, H + 1);
    if (rd) push(EV_ADR, H + 1);
    tick();
    bus.first_cyc = 0; bus.acc_cfg = 0; bus.acc_io = 0; bus.acc_mem = 0;
    ws = H + 1; lim = INIT_LAT;
    for (int ph = 0; ph < nph; ph++) begin
      if (ph == ev_ph && ev_kind == 1) begin
        push(EV_STOP, ws + lim); push(EV_REQF, ws + lim);
        F = ws + lim + int'($urandom_range(0, 3));
        wait_to(F);
        bus.framenid = 1; bus.irdynid = 1;
        push_end(F + 1, rd);
        tick();
        break;
      end
      if (ph == ev_ph && ev_kind == 2) begin
        X = ws + int'($urandom_range(0, lim - 2));
        wait_to(X);
        bus.framenid = 1; bus.irdynid = 1;
        push(EV_REQF, X + 1); push_end(X + 1, rd);
        tick();
        break;
      end
      d = (dfix >= 0) ? dfix : int'($urandom_range(0, lim - 1));
      w = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
      A = ws + d;
      wait_to(A);
      bus.loc_ack = 1;
      push(EV_TRDY, A + 1); push(EV_REQF, A + 1);
      tick();
      bus.loc_ack = 0;
      C = A + 1 + w;
      wait_to(C);
      bus.irdynid = 0;
      if (ph == nph - 1 && !(single && single_hold)) begin
        bus.framenid = 1;
        push(EV_INC, C + 1); push_end(C + 1, rd);
        tick();
        bus.irdynid = 1;
      end else if (single) begin
        push(EV_STOP, C + 1); push(EV_INC, C + 1);
        tick();
        bus.irdynid = 1;
        F = C + 1 + int'($urandom_range(0, 3));
        wait_to(F);
        bus.framenid = 1;
        push_end(F + 1, rd);
        tick();
      end else begin
        push(EV_INC, C + 1); push(EV_REQR, C + 1);
        tick();
        bus.irdynid = 1;
        ws = C + 1; lim = SUBS_LAT;
      end
    end
    bus.acc_rd = 0; bus.acc_wr = 0;
    repeat (3 + $urandom_range(0, 2)) tick();
  endtask

  initial begin
    int R, H, A;
    rst = 0;
    bus.framenid = 1; bus.irdynid = 1; bus.first_cyc = 0; bus.acc_cfg = 0;
    bus.acc_io = 0; bus.acc_mem = 0; bus.acc_rd = 0; bus.acc_wr = 0; bus.loc_ack = 0;
    repeat (3) tick();
    chk("rst_devseln", bus.devseln, 1); chk("rst_trdyn", bus.trdyn, 1);
    chk("rst_stopn", bus.stopn, 1);     chk("rst_tgt_oe", bus.tgt_oe, 0);
    chk("rst_ad_oe", bus.ad_oe, 0);     chk("rst_loc_req", bus.loc_req, 0);
    chk("rst_inc_adr", bus.inc_adr, 0); chk("rst_acc_end", bus.acc_end, 0);
    rst = 1;
    tick();
    mon_en = 1;
    tick();

    run_txn(0, 1, 1, -1, 0, 0, 1, 0);           // cfg read, ack 2 clk after hit
    run_txn(2, 0, 4, -1, 0, 0, 0, 0);           // mem write burst, immediate acks
    run_txn(2, 1, 1, 0, 1, 0, -1, -1);          // mem read, no ack: retry
    run_txn(0, 0, 1, -1, 0, 1, 0, 0);           // cfg write, frame held: disconnect
    run_txn(2, 1, 1, -1, 0, 0, INIT_LAT - 1, 0); // ack on the timeout edge wins
    run_txn(2, 0, 3, 1, 1, 0, 0, 1);            // subsequent-phase timeout
    run_txn(2, 1, 2, 1, 0, 0, SUBS_LAT - 1, 0); // late ack in burst phase
    run_txn(2, 1, 1, 0, 2, 0, -1, -1);          // master abort in WAIT
    run_txn(1, 0, 1, -1, 0, 1, -1, -1);         // io write disconnect

    // Not-for-us address phase, then a hit while FRAME# is still low.
    bus.framenid = 0; bus.irdynid = 1; bus.first_cyc = 1;
    tick();
    bus.first_cyc = 0;
    repeat (2) tick();
    bus.first_cyc = 1; bus.acc_mem = 1; bus.acc_rd = 1;
    tick();
    bus.first_cyc = 0; bus.acc_mem = 0; bus.acc_rd = 0; bus.irdynid = 0;
    repeat (3) tick();
    chk("busy_devseln", bus.devseln, 1);
    chk("busy_tgt_oe", bus.tgt_oe, 0);
    bus.framenid = 1; bus.irdynid = 1;
    repeat (2) tick();
    run_txn(2, 0, 2, -1, 0, 0, -1, -1);         // claimed once bus idle

    // Reset while in DATA: outputs return to reset values, no acc_end.
    bus.framenid = 0; bus.irdynid = 1; bus.first_cyc = 1; bus.acc_mem = 1; bus.acc_rd = 1;
    H = cyc;
    push(EV_DEV, H + 1); push(EV_REQR, H + 1); push(EV_OER, H + 1); push(EV_ADR, H + 1);
    tick();
    bus.first_cyc = 0; bus.acc_mem = 0;
    A = cyc;
    bus.loc_ack = 1;
    push(EV_TRDY, A + 1); push(EV_REQF, A + 1);
    tick();
    bus.loc_ack = 0;
    repeat (2) tick();
    R = cyc;
    rst = 0;
    push(EV_OEF, R + 1); push(EV_ADF, R + 1);
    tick();
    rst = 1; bus.framenid = 1; bus.irdynid = 1; bus.acc_rd = 0;
    chk("mid_rst_devseln", bus.devseln, 1); chk("mid_rst_trdyn", bus.trdyn, 1);
    chk("mid_rst_stopn", bus.stopn, 1);     chk("mid_rst_tgt_oe", bus.tgt_oe, 0);
    chk("mid_rst_ad_oe", bus.ad_oe, 0);     chk("mid_rst_loc_req", bus.loc_req, 0);
    chk("mid_rst_acc_end", bus.acc_end, 0);
    repeat (4) tick();
    run_txn(0, 1, 1, -1, 0, 0, -1, -1);         // claimed normally after reset

    for (int n = 0; n < 25; n++) begin
      int sp, r, kind, evph, nph;
      sp   = int'($urandom_range(0, 2));
      nph  = int'($urandom_range(1, 4));
      r    = int'($urandom_range(0, 9));
      kind = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      evph = (kind != 0) ? int'($urandom_range(0, nph - 1)) : -1;
      run_txn(sp, 1'($urandom_range(0, 1)), nph, evph, kind,
              1'($urandom_range(0, 1)), -1, -1);
    end

    repeat (5) tick();
    chk("events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pci_tgt_seq.md
Name: pci_tgt_seq

Overview:
Target-side bus sequencer for the PCI slave interface.
- Consumes the decoded access qualifiers from the command/address capture stage: first_cyc, acc_cfg, acc_io, acc_mem, acc_rd, acc_wr.
- Drives devsel#/trdy#/stop# and their output enables.
- Paces the local register/memory side with a request/ack handshake.
- Generates inc_adr and acc_end back to the capture stage.
- Enforces PCI initial (16 clk) and subsequent (8 clk) target latency by retry or disconnect.

Parameters:
INIT_LAT, 16, clocks from devsel assertion to first trdy before target retry
SUBS_LAT, 8, clocks allowed per subsequent data phase before disconnect-without-data
CNT_W, 5, latency counter width; must hold INIT_LAT

Ports:
rst  in  1  synchronous reset, active low
clk  in  1  PCI clock; all state changes on rising edge
framenid  in  1  registered FRAME#
irdynid  in  1  registered IRDY#
first_cyc  in  1  address phase strobe (FRAME# falling edge)
acc_cfg  in  1  config hit, valid while first_cyc=1
acc_io  in  1  I/O space hit, valid while first_cyc=1
acc_mem  in  1  memory space hit, valid while first_cyc=1
acc_rd  in  1  latched read access
acc_wr  in  1  latched write access
loc_ack  in  1  local side: data accepted (write) or valid (read), one-cycle pulse
devseln  out  1  DEVSEL# value
trdyn  out  1  TRDY# value
stopn  out  1  STOP# value
tgt_oe  out  1  enable for devsel#/trdy#/stop# drivers
ad_oe  out  1  enable AD drivers (reads only)
loc_req  out  1  local request, held until loc_ack or abort
inc_adr  out  1  one-cycle pulse: advance address after a completed data phase
acc_end  out  1  one-cycle pulse: transaction over, clears latched command

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE.
  - devseln=trdyn=stopn=1.
  - tgt_oe=ad_oe=loc_req=inc_adr=acc_end=0.
  - Latency counter cleared.
  - Reset mid-transaction abandons it silently; no acc_end pulse.
- States: IDLE, BUSY, WAIT, DATA, STOP, TURN.
- hit = first_cyc & (acc_cfg|acc_io|acc_mem); single = latched (acc_cfg|acc_io) at hit.
- IDLE:
  - On hit: go to WAIT. devseln=0 and tgt_oe=1 from the next cycle (medium decode). Counter loads INIT_LAT.
  - On first_cyc without hit: go to BUSY.
- BUSY: ignore the bus until framenid=1 & irdynid=1, then IDLE. A hit is never taken in BUSY.
- WAIT:
  - loc_req=1; ad_oe=acc_rd.
  - Counter decrements each cycle.
  - loc_ack → DATA, trdyn=0 on the next cycle. loc_req drops on the same cycle as loc_ack.
  - Counter reaches 0 before loc_ack → STOP with trdyn=1 (retry on the first phase, disconnect on later phases). loc_req drops.
  - loc_ack and timeout on the same cycle: loc_ack wins.
- DATA: a phase completes on the cycle where trdyn=0 & irdynid=0.
  - Completion with framenid=1 (last phase) → TURN. Pulse inc_adr.
  - Completion with framenid=0 and single=1 → STOP with trdyn=1. Pulse inc_adr. This is the cfg/io single-phase disconnect.
  - Completion with framenid=0 and single=0 → WAIT. Pulse inc_adr. Counter loads SUBS_LAT. trdyn=1 again.
  - Irdy wait states: remain in DATA, hold trdyn=0.
- STOP:
  - stopn=0, devseln=0, trdyn=1.
  - Hold until framenid=1, then TURN.
- TURN:
  - devseln=trdyn=stopn=1, tgt_oe=1, ad_oe=0.
  - Pulse acc_end.
  - Next state IDLE, where tgt_oe=0.
- Master abort / framenid=1 while in WAIT with irdynid=1: treat as end → TURN. No inc_adr.
- inc_adr and acc_end never assert on the same cycle.
- acc_end asserts exactly once per claimed transaction.
- Counter is unsigned CNT_W bits, saturating at 0.

Decomposition:
- Shared package pci_pkg:
  - State encoding constants (IDLE..TURN).
  - Command codes (config/io/mem read/write).
  - INIT_LAT/SUBS_LAT defaults.
- One natural sub-module: pci_lat_cnt. Loadable down-counter with load, dec, zero flag.
- FSM and output registers stay in pci_tgt_seq.

Test Plan:
- Config read, loc_ack 2 clk after hit, irdy low, frame deasserted with irdy:
  - devseln low 1 clk after first_cyc; trdyn low 1 clk after loc_ack.
  - One inc_adr; acc_end in TURN; back to IDLE.
- Memory write burst of 4 phases, loc_ack immediate each phase:
  - 4 inc_adr pulses; trdyn toggles 0/1 per phase; single acc_end.
  - stopn never asserted.
- Memory read, loc_ack never returns:
  - stopn=0 with trdyn=1 exactly INIT_LAT clk after devseln falls.
  - Master raises frame → TURN, acc_end; loc_req cleared.
- Config write, frame held low after first data phase:
  - After trdy&irdy, stopn=0 next clk.
  - Hold until frame high, then TURN.
- Non-hit address phase followed by a hit address while frame still low:
  - Stays in BUSY; no devseln; waits for idle bus (frame=irdy=1).
- rst=0 asserted while in DATA:
  - Next clk all outputs at reset values; no acc_end.
  - New hit afterwards is claimed normally.
